// File: rtl/sum_nk_pkg.sv
// rtl/sum_nk_pkg.sv - shared state type and sizing helpers for the sum_nk_pipe reduction engine
package sum_nk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int lane_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

  function automatic int accum_steps(input int n, input int p);
    return (n + p - 1) / p;
  endfunction

  function automatic int reduce_steps(input int p);
    return $clog2(p);
  endfunction

  // Operand consumed by lane j on accumulation step k.
  function automatic int op_index(input int k, input int p, input int j);
    return k * p + j;
  endfunction

endpackage

// File: rtl/sum_nk_lane.sv
// rtl/sum_nk_lane.sv - one accumulation lane: a register plus a single adder
// The addend is the lane's operand while accumulating and its partner lane while reducing.
module sum_nk_lane #(
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_reduce,
  input  logic [LW-1:0] i_operand,
  input  logic [LW-1:0] i_partner,
  output logic [LW-1:0] o_acc
);

  logic [LW-1:0] r_acc;
  logic [LW-1:0] w_addend;

  assign w_addend = i_reduce ? i_partner : i_operand;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_addend;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/sum_nk_pipe.sv
// rtl/sum_nk_pipe.sv - sums N W-bit operands over P lanes in ceil(N/P)+ceil(log2 P) cycles
// Define SUM_NK_SIGNED_EN for two's-complement operands (sign-extended into the lanes).
module sum_nk_pipe
  import sum_nk_pkg::*;
#(
  parameter int N = 10,
  parameter int W = 5,
  parameter int P = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*W-1:0]          nums,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W+$clog2(N)-1:0]  sum,
  output logic                    busy
);

  localparam int LW  = lane_width(N, W);
  localparam int A   = accum_steps(N, P);
  localparam int KW  = (A > 1) ? $clog2(A) : 1;
  localparam int LCW = $clog2(P + 1);
  localparam int EXT = LW - W;

  state_t           r_state;
  logic [N*W-1:0]   r_nums;
  logic [KW-1:0]    r_k;
  logic [LCW-1:0]   r_live;

  logic [LW-1:0]    w_ext     [N];
  logic [LW-1:0]    w_operand [P];
  logic [LW-1:0]    w_partner [P];
  logic [LW-1:0]    w_lane    [P];
  logic [P-1:0]     w_en;
  logic [LCW-1:0]   w_half;
  logic             w_clr;
  logic             w_reduce;

  assign w_clr    = (r_state == IDLE) && in_valid;
  assign w_reduce = (r_state == REDUCE);
  assign w_half   = LCW'((int'(r_live) + 1) / 2);

  always_comb begin
    for (int m = 0; m < N; m++) begin
`ifdef SUM_NK_SIGNED_EN
      w_ext[m] = {{EXT{r_nums[m*W+W-1]}}, r_nums[m*W +: W]};
`else
      w_ext[m] = {{EXT{1'b0}}, r_nums[m*W +: W]};
`endif
    end
  end

  // Lanes whose operand index runs past N add zero; upper-half lanes feed the lower half while reducing.
  always_comb begin
    for (int j = 0; j < P; j++) begin
      w_operand[j] = '0;
      w_partner[j] = '0;
      for (int m = 0; m < N; m++) begin
        if (m == op_index(int'(r_k), P, j)) w_operand[j] = w_ext[m];
      end
      for (int m = 0; m < P; m++) begin
        if (m == j + int'(w_half)) w_partner[j] = w_lane[m];
      end
      w_en[j] = (r_state == ACCUM) || (w_reduce && (j < int'(r_live) / 2));
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    sum_nk_lane #(.LW(LW)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_en      (w_en[j]),
      .i_reduce  (w_reduce),
      .i_operand (w_operand[j]),
      .i_partner (w_partner[j]),
      .o_acc     (w_lane[j])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_nums  <= '0;
      r_k     <= '0;
      r_live  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_nums  <= nums;
            r_k     <= '0;
            r_live  <= LCW'(P);
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (r_k == KW'(A - 1)) begin
            r_state <= (P == 1) ? DONE : REDUCE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        REDUCE: begin
          r_live <= w_half;
          if (w_half == LCW'(1)) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == ACCUM) || (r_state == REDUCE);
  assign sum       = w_lane[0];

endmodule

// File: tb/tb_sum_nk_pipe.sv
// tb/tb_sum_nk_pipe.sv - randomized self-checking bench for sum_nk_pipe against an arithmetic model
module tb_sum_nk_pipe;

  localparam int MN  = 10;
  localparam int MW  = 5;
  localparam int MP  = 3;
  localparam int MLW = MW + $clog2(MN);

  logic clk;
  logic rst_main;
  logic rst_sweep;
  logic in_valid;
  logic in_ready;
  logic [MN*MW-1:0] nums;
  logic out_valid;
  logic out_ready;
  logic [MLW-1:0] sum;
  logic busy;

  int n_checks = 0;
  int n_fail = 0;
  int sweeps_done = 0;

  sum_nk_pipe #(.N(MN), .W(MW), .P(MP)) u_dut (
    .clk       (clk),
    .rst       (rst_main),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .nums      (nums),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // True arithmetic sum of the operand vector, reduced to the lane width.
  function automatic logic [63:0] model_lane(input logic [63:0] v, input int n, input int w);
    longint s;
    longint op;
    int lw;
    s = 0;
    lw = w + $clog2(n);
    for (int i = 0; i < n; i++) begin
      op = longint'((v >> (i * w)) & ((64'd1 << w) - 64'd1));
`ifdef SUM_NK_SIGNED_EN
      if (op >= (longint'(1) << (w - 1))) op = op - (longint'(1) << w);
`endif
      s = s + op;
    end
    return 64'(s) & ((64'd1 << lw) - 64'd1);
  endfunction

  function automatic int model_lat(input int n, input int p);
    int r;
    r = 0;
    while ((1 << r) < p) r++;
    return (n + p - 1) / p + r;
  endfunction

  function automatic logic [MN*MW-1:0] fill_main(input logic [MW-1:0] val);
    logic [MN*MW-1:0] v;
    for (int i = 0; i < MN; i++) v[i*MW +: MW] = val;
    return v;
  endfunction

  function automatic logic [MN*MW-1:0] rand_main();
    logic [MN*MW-1:0] v;
    for (int i = 0; i < MN; i++) v[i*MW +: MW] = MW'($urandom);
    return v;
  endfunction

  task automatic run_vec(input logic [MN*MW-1:0] v, input int bp, input bit hold_iv,
                         input logic [MN*MW-1:0] alt);
    int lat;
    logic [MLW-1:0] held;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    nums = v;
    in_valid = 1'b1;
    out_ready = (bp == 0);
    @(negedge clk);
    if (hold_iv) begin
      nums = alt;
    end else begin
      in_valid = 1'b0;
      nums = rand_main();
    end
    lat = 0;
    while (!out_valid && lat < 60) begin
      check("in_ready_busy", in_ready, 0);
      check("busy_high", busy, 1);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, model_lat(MN, MP));
    check("sum", sum, model_lane(64'(v), MN, MW));
    check("busy_done", busy, 0);
    held = sum;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum_stable", sum, held);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", out_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  function automatic int cfg_n(input int g);
    return (g == 2) ? 7 : 10;
  endfunction

  function automatic int cfg_p(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 10 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int GN  = cfg_n(g);
    localparam int GP  = cfg_p(g);
    localparam int GLW = MW + $clog2(GN);

    logic s_in_valid;
    logic s_in_ready;
    logic s_out_valid;
    logic s_out_ready;
    logic s_busy;
    logic [GN*MW-1:0] s_nums;
    logic [GLW-1:0] s_sum;

    sum_nk_pipe #(.N(GN), .W(MW), .P(GP)) u_dut (
      .clk       (clk),
      .rst       (rst_sweep),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .nums      (s_nums),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .sum       (s_sum),
      .busy      (s_busy)
    );

    initial begin
      int lat;
      s_in_valid = 1'b0;
      s_out_ready = 1'b1;
      s_nums = '0;
      repeat (6) @(negedge clk);
      for (int v = 0; v < 4; v++) begin
        for (int i = 0; i < GN; i++) s_nums[i*MW +: MW] = (v == 0) ? 5'h1f : 5'($urandom);
        check($sformatf("sweep%0d_in_ready", g), s_in_ready, 1);
        s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 60) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("sweep%0d_latency", g), lat, model_lat(GN, GP));
        check($sformatf("sweep%0d_sum", g), s_sum, model_lane(64'(s_nums), GN, MW));
        @(negedge clk);
        check($sformatf("sweep%0d_drop", g), s_out_valid, 0);
      end
      sweeps_done++;
    end
  end

  initial begin
    logic [MN*MW-1:0] seq;
    int saw_valid;
    int t;
    rst_main = 1'b0;
    rst_sweep = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    nums = '0;
    for (int i = 0; i < MN; i++) seq[i*MW +: MW] = MW'(i + 1);

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    rst_main = 1'b1;
    rst_sweep = 1'b1;

    run_vec(fill_main(5'h1f), 0, 1'b0, '0);
    run_vec(seq, 0, 1'b0, '0);
    run_vec(seq, 3, 1'b0, '0);

    run_vec(seq, 0, 1'b1, fill_main(5'd2));
    repeat (3) begin
      @(negedge clk);
      check("no_queue_valid", out_valid, 0);
      check("no_queue_ready", in_ready, 1);
    end
    run_vec(fill_main(5'd2), 0, 1'b0, '0);

    // Abort in the middle of accumulation.
    @(negedge clk);
    nums = seq;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_main = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_valid", out_valid, 0);
    @(negedge clk);
    rst_main = 1'b1;
    saw_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw_valid++;
    end
    check("abort_no_valid", saw_valid, 0);
    run_vec(fill_main(5'd1), 0, 1'b0, '0);

    run_vec(fill_main(5'h10), 1, 1'b0, '0);
    for (int k = 0; k < 12; k++) begin
      run_vec(rand_main(), $urandom_range(0, 3), 1'b0, '0);
    end

    t = 0;
    while (sweeps_done < 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("sweeps_complete", sweeps_done, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
